// File: rtl/commit_trace_buffer_pkg.sv
// Shared prv664 types: retire trace record and counter widths.
package prv664_pkg;

    localparam int XLEN      = 64;
    localparam int DROPCNT_W = 16;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [7:0]      itag;
        logic [4:0]      opcode;
        logic            mmio;
        logic            trap;
        logic            trap_async;
        logic [XLEN-1:0] trap_cause;
        logic [XLEN-1:0] trap_value;
    } trace_rec_t;

    function automatic logic [DROPCNT_W-1:0] sat_inc(input logic [DROPCNT_W-1:0] v);
        return (v == '1) ? v : v + DROPCNT_W'(1);
    endfunction

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Retire stream from the commit stage; one record per valid cycle, no backpressure.
interface instr_commit_interface;
    import prv664_pkg::*;

    logic            valid;
    logic [XLEN-1:0] pc;
    logic [7:0]      itag;
    logic [4:0]      opcode;
    logic            mmio;
    logic            trap_s;
    logic            trap_m;
    logic            trap_d;
    logic            trap_async;
    logic [XLEN-1:0] trap_cause;
    logic [XLEN-1:0] trap_value;

    modport master (output valid, pc, itag, opcode, mmio, trap_s, trap_m, trap_d,
                           trap_async, trap_cause, trap_value);
    modport slave  (input  valid, pc, itag, opcode, mmio, trap_s, trap_m, trap_d,
                           trap_async, trap_cause, trap_value);
endinterface

// File: rtl/commit_trace_buffer_fifo.sv
// Trace record FIFO, write-to-head latency 1 (no bypass).
// Backpressure: push when full is refused unless a pop happens in the same cycle.
module commit_trace_fifo import prv664_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   push,
    input  trace_rec_t             wdata,
    input  logic                   ready,
    output trace_rec_t             rdata,
    output logic                   valid,
    output logic                   drop,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          full;
    logic          pop;
    logic          push_ok;
    trace_rec_t    mem [DEPTH];

    assign valid   = (cnt != '0);
    assign full    = (cnt == CW'(DEPTH));
    assign pop     = valid && ready;
    // A simultaneous pop frees the slot the push needs, so full only blocks a lone push.
    assign push_ok = push && (!full || pop);
    assign drop    = push && full && !pop;
    assign count   = cnt;
    assign rdata   = mem[rptr];

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (push_ok) wptr <= wptr + AW'(1);
            if (pop)     rptr <= rptr + AW'(1);
            if (push_ok && !pop)      cnt <= cnt + CW'(1);
            else if (pop && !push_ok) cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire trace buffer: FIFO of commit records plus instret/trap/drop counters, latency 1.
// Backpressure: consumer stalls via trace_ready_i; records arriving while full are dropped and counted.
module commit_trace_buffer import prv664_pkg::*; #(
    parameter int DEPTH = 8
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    instr_commit_interface.slave   commit,
    input  logic                   inhibit_i,
    input  logic                   clr_i,
    output logic                   trace_valid_o,
    input  logic                   trace_ready_i,
    output logic [XLEN-1:0]        trace_pc_o,
    output logic [7:0]             trace_itag_o,
    output logic [4:0]             trace_opcode_o,
    output logic                   trace_mmio_o,
    output logic                   trace_trap_o,
    output logic                   trace_async_o,
    output logic [XLEN-1:0]        trace_cause_o,
    output logic [XLEN-1:0]        trace_tval_o,
    output logic [63:0]            instret_o,
    output logic [31:0]            trapcnt_o,
    output logic                   overflow_o,
    output logic [DROPCNT_W-1:0]   dropcnt_o,
    output logic [$clog2(DEPTH):0] count_o
);

    if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("commit_trace_buffer: DEPTH must be a power of two in 2..64");
    end

    trace_rec_t rec;
    trace_rec_t head;
    logic       is_trap;
    logic       drop;

    assign is_trap = commit.trap_s | commit.trap_m | commit.trap_d;

    always_comb begin
        rec            = '0;
        rec.pc         = commit.pc;
        rec.itag       = commit.itag;
        rec.opcode     = commit.opcode;
        rec.mmio       = commit.mmio;
        rec.trap       = is_trap;
        rec.trap_async = commit.trap_async;
        rec.trap_cause = commit.trap_cause;
        rec.trap_value = commit.trap_value;
    end

    commit_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .push     (commit.valid),
        .wdata    (rec),
        .ready    (trace_ready_i),
        .rdata    (head),
        .valid    (trace_valid_o),
        .drop     (drop),
        .count    (count_o)
    );

    assign trace_pc_o     = head.pc;
    assign trace_itag_o   = head.itag;
    assign trace_opcode_o = head.opcode;
    assign trace_mmio_o   = head.mmio;
    assign trace_trap_o   = head.trap;
    assign trace_async_o  = head.trap_async;
    assign trace_cause_o  = head.trap_cause;
    assign trace_tval_o   = head.trap_value;

    // Counters see every retirement, whether or not the record made it into the FIFO.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            instret_o  <= '0;
            trapcnt_o  <= '0;
            overflow_o <= 1'b0;
            dropcnt_o  <= '0;
        end else begin
            if (commit.valid && !is_trap && !inhibit_i) instret_o <= instret_o + 64'd1;
            if (commit.valid && is_trap)                trapcnt_o <= trapcnt_o + 32'd1;
            if (clr_i) begin
                overflow_o <= drop;
                dropcnt_o  <= drop ? DROPCNT_W'(1) : '0;
            end else if (drop) begin
                overflow_o <= 1'b1;
                dropcnt_o  <= sat_inc(dropcnt_o);
            end
        end
    end

endmodule
